rr_sched_engine_param: RTL and testbench

- Parametrised next-generation TCP transmit scheduler. Holds per-flow pending flags in flop arrays, which gives single-cycle read-modify-write with no RAM read latency.
- Arbitrates update commands from NUM_SRCS producers round-robin.
- Scans allocated flows with a round-robin pointer and issues one scheduling request per flow that has any flag set.
- Adds flow deallocation, optional clear-on-grant and fully defined collision rules. Sits between the app/RX/TX engines and the TX request path.

---
 rtl/tcp_misc_pkg.sv | 20 ++
 rtl/bsg_arb_round_robin.sv | 43 ++++
 rtl/sched_flag_vec_update.sv | 24 ++
 rtl/rr_sched_engine_param.sv | 156 +++++++++++++++
 tb/tb_rr_sched_engine_param.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_misc_pkg.sv
// Shared TCP scheduler definitions: per-flag command encoding, flag bit positions, find-FSM states.
package tcp_misc_pkg;

  typedef enum logic [1:0] {
    SCHED_FLAG_NOP = 2'b00,
    SCHED_FLAG_SET = 2'b01,
    SCHED_FLAG_CLR = 2'b10,
    SCHED_FLAG_RSV = 2'b11
  } sched_flag_cmd_e;

  localparam int SCHED_FLAG_RT   = 0;
  localparam int SCHED_FLAG_ACK  = 1;
  localparam int SCHED_FLAG_DATA = 2;

  typedef enum logic {
    SCHED_ST_SCAN   = 1'b0,
    SCHED_ST_OUTPUT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: one-hot grant among reqs_i, priority moves past the winner on yumi_i.
// Latency: grant is combinational; priority update at the next edge.
// Backpressure: without yumi_i the priority holds and the same winner is offered again.
module bsg_arb_round_robin #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] reqs_i,
  output logic [width_p-1:0] grants_o,
  input  logic               yumi_i
);
  localparam int PTR_W = (width_p > 1) ? $clog2(width_p) : 1;

  logic [PTR_W-1:0] prio_q;
  logic [PTR_W-1:0] prio_nxt;

  function automatic int rr_idx(input int p, input int k);
    return (p + k) % width_p;
  endfunction

  // Walk from lowest to highest priority so the highest-priority requester wins last.
  always_comb begin
    grants_o = '0;
    prio_nxt = prio_q;
    for (int k = width_p - 1; k >= 0; k--) begin
      if (reqs_i[PTR_W'(rr_idx(int'(prio_q), k))]) begin
        grants_o = '0;
        grants_o[PTR_W'(rr_idx(int'(prio_q), k))] = 1'b1;
        prio_nxt = PTR_W'(rr_idx(int'(prio_q), k + 1));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= '0;
    end else if (yumi_i) begin
      prio_q <= prio_nxt;
    end
  end

endmodule

// File: rtl/sched_flag_vec_update.sv
// Applies a per-flag SET/CLEAR/NOP command vector to a flow's pending flags.
// Latency: combinational. Backpressure: none.
module sched_flag_vec_update
  import tcp_misc_pkg::*;
#(
  parameter int NUM_FLAGS = 3
) (
  input  logic [NUM_FLAGS-1:0]   flags_cur,
  input  logic [2*NUM_FLAGS-1:0] flag_cmd,
  output logic [NUM_FLAGS-1:0]   flags_nxt
);

  always_comb begin
    flags_nxt = flags_cur;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      case (sched_flag_cmd_e'(flag_cmd[2*f +: 2]))
        SCHED_FLAG_SET: flags_nxt[f] = 1'b1;
        SCHED_FLAG_CLR: flags_nxt[f] = 1'b0;
        default:        flags_nxt[f] = flags_cur[f];
      endcase
    end
  end

endmodule

// File: rtl/rr_sched_engine_param.sv
// TCP transmit scheduler: per-flow flags in flops, round-robin update arbiter, one flow scanned per cycle.
// Latency: updates visible to the scan next cycle; a hit raises the request one cycle later.
// Backpressure: request held stable until tx_sched_req_rdy; accepted updates are never stalled.
module rr_sched_engine_param
  import tcp_misc_pkg::*;
#(
  parameter int NUM_SRCS     = 3,
  parameter int FLOWID_W     = 8,
  parameter int NUM_FLAGS    = 3,
  parameter int CLR_ON_GRANT = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRCS-1:0]             upd_val,
  input  logic [NUM_SRCS*FLOWID_W-1:0]    upd_flowid,
  input  logic [NUM_SRCS*2*NUM_FLAGS-1:0] upd_flag_cmd,
  output logic [NUM_SRCS-1:0]             upd_rdy,
  input  logic                            new_flow_val,
  input  logic [FLOWID_W-1:0]             new_flow_flowid,
  input  logic                            del_flow_val,
  input  logic [FLOWID_W-1:0]             del_flow_flowid,
  output logic                            sched_tx_req_val,
  output logic [FLOWID_W-1:0]             sched_tx_req_flowid,
  output logic [NUM_FLAGS-1:0]            sched_tx_req_flags,
  input  logic                            tx_sched_req_rdy,
  output logic [FLOWID_W:0]               active_flow_cnt
);
  localparam int MAX_FLOWS = 1 << FLOWID_W;

  logic [MAX_FLOWS-1:0] alloc;
  logic [NUM_FLAGS-1:0] flags [MAX_FLOWS];
  logic [FLOWID_W-1:0]  ptr;
  logic [FLOWID_W:0]    flow_cnt;
  sched_state_e         state;
  logic                 req_val;
  logic [FLOWID_W-1:0]  req_flowid;
  logic [NUM_FLAGS-1:0] req_flags;

  logic [NUM_SRCS-1:0]    grant;
  logic                   upd_any;
  logic [FLOWID_W-1:0]    upd_id;
  logic [2*NUM_FLAGS-1:0] upd_cmd;
  logic [NUM_FLAGS-1:0]   upd_base;
  logic [NUM_FLAGS-1:0]   upd_nxt;
  logic                   upd_apply;
  logic                   hs;
  logic                   clr_hit;
  logic                   new_eff;
  logic                   del_eff;

  assign upd_any = (|upd_val) && !rst;
  assign upd_rdy = rst ? '0 : grant;

  bsg_arb_round_robin #(.width_p(NUM_SRCS)) u_arb (
    .clk_i   (clk),
    .reset_i (rst),
    .reqs_i  (upd_val),
    .grants_o(grant),
    .yumi_i  (upd_any)
  );

  always_comb begin
    upd_id  = '0;
    upd_cmd = '0;
    for (int s = 0; s < NUM_SRCS; s++) begin
      if (grant[s]) begin
        upd_id  = upd_flowid[s*FLOWID_W +: FLOWID_W];
        upd_cmd = upd_flag_cmd[s*2*NUM_FLAGS +: 2*NUM_FLAGS];
      end
    end
  end

  assign hs      = (state == SCHED_ST_OUTPUT) && tx_sched_req_rdy;
  assign clr_hit = (CLR_ON_GRANT != 0) && hs;

  // A same-cycle update lands on top of the grant clear, so its SET/CLEAR bits win.
  assign upd_base  = (clr_hit && (req_flowid == upd_id)) ? '0 : flags[upd_id];
  assign upd_apply = upd_any && alloc[upd_id];

  sched_flag_vec_update #(.NUM_FLAGS(NUM_FLAGS)) u_flag_upd (
    .flags_cur(upd_base),
    .flag_cmd (upd_cmd),
    .flags_nxt(upd_nxt)
  );

  assign new_eff = new_flow_val && !alloc[new_flow_flowid]
                   && !(del_flow_val && (del_flow_flowid == new_flow_flowid));
  assign del_eff = del_flow_val && alloc[del_flow_flowid];

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc    <= '0;
      flow_cnt <= '0;
      for (int i = 0; i < MAX_FLOWS; i++) begin
        flags[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_FLOWS; i++) begin
        if (del_flow_val && (del_flow_flowid == FLOWID_W'(i))) begin
          alloc[i] <= 1'b0;
          flags[i] <= '0;
        end else if (new_flow_val && (new_flow_flowid == FLOWID_W'(i))) begin
          alloc[i] <= 1'b1;
          flags[i] <= '0;
        end else if (upd_apply && (upd_id == FLOWID_W'(i))) begin
          flags[i] <= upd_nxt;
        end else if (clr_hit && (req_flowid == FLOWID_W'(i))) begin
          flags[i] <= '0;
        end
      end
      if (new_eff && !del_eff) begin
        flow_cnt <= flow_cnt + (FLOWID_W+1)'(1);
      end else if (!new_eff && del_eff) begin
        flow_cnt <= flow_cnt - (FLOWID_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCHED_ST_SCAN;
      ptr        <= '0;
      req_val    <= 1'b0;
      req_flowid <= '0;
      req_flags  <= '0;
    end else begin
      case (state)
        SCHED_ST_SCAN: begin
          if (alloc[ptr] && (|flags[ptr])) begin
            req_val    <= 1'b1;
            req_flowid <= ptr;
            req_flags  <= flags[ptr];
            state      <= SCHED_ST_OUTPUT;
          end else begin
            ptr <= ptr + FLOWID_W'(1);
          end
        end
        SCHED_ST_OUTPUT: begin
          // Resume just past the granted flow so it re-qualifies only after a full wrap.
          if (tx_sched_req_rdy) begin
            req_val <= 1'b0;
            ptr     <= req_flowid + FLOWID_W'(1);
            state   <= SCHED_ST_SCAN;
          end
        end
        default: state <= SCHED_ST_SCAN;
      endcase
    end
  end

  assign sched_tx_req_val    = req_val;
  assign sched_tx_req_flowid = req_flowid;
  assign sched_tx_req_flags  = req_flags;
  assign active_flow_cnt     = flow_cnt;

endmodule

// File: tb/tb_rr_sched_engine_param.sv
// Directed bench for rr_sched_engine_param: one instance without and one with clear-on-grant.
module tb_rr_sched_engine_param;
  import tcp_misc_pkg::*;

  localparam int NS   = 3;
  localparam int FW   = 8;
  localparam int NF   = 3;
  localparam int MAXF = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     upd_val;
  logic [NS*FW-1:0]  upd_flowid;
  logic [NS*2*NF-1:0] upd_flag_cmd;
  logic              new_flow_val;
  logic [FW-1:0]     new_flow_flowid;
  logic              del_flow_val;
  logic [FW-1:0]     del_flow_flowid;
  logic              rdy;

  logic [NS-1:0] a_upd_rdy, b_upd_rdy;
  logic          a_val, b_val;
  logic [FW-1:0] a_id, b_id;
  logic [NF-1:0] a_flags, b_flags;
  logic [FW:0]   a_cnt, b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_sched_engine_param #(.NUM_SRCS(NS), .FLOWID_W(FW), .NUM_FLAGS(NF), .CLR_ON_GRANT(0)) u_dut_a (
    .clk(clk), .rst(rst), .upd_val(upd_val), .upd_flowid(upd_flowid), .upd_flag_cmd(upd_flag_cmd),
    .upd_rdy(a_upd_rdy), .new_flow_val(new_flow_val), .new_flow_flowid(new_flow_flowid),
    .del_flow_val(del_flow_val), .del_flow_flowid(del_flow_flowid), .sched_tx_req_val(a_val),
    .sched_tx_req_flowid(a_id), .sched_tx_req_flags(a_flags), .tx_sched_req_rdy(rdy),
    .active_flow_cnt(a_cnt));

  rr_sched_engine_param #(.NUM_SRCS(NS), .FLOWID_W(FW), .NUM_FLAGS(NF), .CLR_ON_GRANT(1)) u_dut_b (
    .clk(clk), .rst(rst), .upd_val(upd_val), .upd_flowid(upd_flowid), .upd_flag_cmd(upd_flag_cmd),
    .upd_rdy(b_upd_rdy), .new_flow_val(new_flow_val), .new_flow_flowid(new_flow_flowid),
    .del_flow_val(del_flow_val), .del_flow_flowid(del_flow_flowid), .sched_tx_req_val(b_val),
    .sched_tx_req_flowid(b_id), .sched_tx_req_flags(b_flags), .tx_sched_req_rdy(rdy),
    .active_flow_cnt(b_cnt));

  typedef struct {
    logic [NS-1:0] val;
    logic [NS-1:0] exp_rdy;
  } arb_vec_t;

  arb_vec_t arb_tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input int src, input int id, input int flag, input sched_flag_cmd_e cmd);
    logic [2*NF-1:0] c;
    c = '0;
    c[2*flag +: 2] = cmd;
    upd_val[src] = 1'b1;
    upd_flowid[src*FW +: FW] = FW'(id);
    upd_flag_cmd[src*2*NF +: 2*NF] = c;
  endtask

  task automatic do_reset();
    rst = 1'b1; upd_val = '0; new_flow_val = 1'b0; del_flow_val = 1'b0; rdy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic alloc_flow(input int id);
    new_flow_val = 1'b1; new_flow_flowid = FW'(id);
    step();
    new_flow_val = 1'b0;
  endtask

  task automatic wait_val(input bit use_b, input int limit, output bit got);
    got = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (use_b ? b_val : a_val) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic count_reqs(input bit use_b, input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      if (use_b ? b_val : a_val) cnt++;
      step();
    end
  endtask

  initial begin
    bit got;
    int nreq;
    int gcnt[NS];
    int ids[6];
    int at[6];
    int k;
    int exp_ids[6];
    int exp_gap[6];

    // Reset: requests present on upd_val must not be granted while rst is high.
    rst = 1'b1; rdy = 1'b0; new_flow_val = 1'b0; del_flow_val = 1'b0;
    new_flow_flowid = '0; del_flow_flowid = '0;
    upd_val = '1; upd_flowid = {NS{8'd200}}; upd_flag_cmd = {NS{6'b00_00_01}};
    step(); step();
    chk("rst_upd_rdy_a", a_upd_rdy, 0);
    chk("rst_upd_rdy_b", b_upd_rdy, 0);
    chk("rst_val_a", a_val, 0);
    chk("rst_val_b", b_val, 0);
    chk("rst_cnt_a", a_cnt, 0);
    upd_val = '0; rst = 1'b0;
    step();

    // Arbiter: nine all-busy cycles, then mixed patterns; targets unallocated flow 200.
    for (int i = 0; i < 9; i++) arb_tbl[i] = '{3'b111, 3'(1 << (i % 3))};
    arb_tbl[9]  = '{3'b110, 3'b010};
    arb_tbl[10] = '{3'b101, 3'b100};
    arb_tbl[11] = '{3'b011, 3'b001};
    arb_tbl[12] = '{3'b000, 3'b000};
    arb_tbl[13] = '{3'b100, 3'b100};
    arb_tbl[14] = '{3'b010, 3'b010};
    arb_tbl[15] = '{3'b011, 3'b001};
    for (int s = 0; s < NS; s++) gcnt[s] = 0;
    for (int i = 0; i < 16; i++) begin
      upd_val = arb_tbl[i].val;
      #1;
      chk($sformatf("arb_row%0d", i), a_upd_rdy, arb_tbl[i].exp_rdy);
      if (i < 9) for (int s = 0; s < NS; s++) if (a_upd_rdy[s]) gcnt[s]++;
      step();
    end
    upd_val = '0;
    for (int s = 0; s < NS; s++) chk($sformatf("arb_grants_src%0d", s), gcnt[s], 3);
    chk("unalloc_upd_no_req", a_val, 0);

    // Flow 7 ack request, held stable under backpressure.
    alloc_flow(3);
    alloc_flow(7);
    chk("cnt_after_alloc", a_cnt, 2);
    set_upd(1, 7, SCHED_FLAG_ACK, SCHED_FLAG_SET);
    #1;
    chk("upd_rdy_src1", a_upd_rdy, 3'b010);
    step();
    upd_val = '0;
    wait_val(1'b0, MAXF + 2, got);
    chk("req7_seen", got, 1);
    chk("req7_id", a_id, 7);
    chk("req7_flags", a_flags, 3'b010);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("req7_hold%0d", i), {a_val, a_id, a_flags}, {1'b1, 8'd7, 3'b010});
    end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("req7_drop_after_hs", a_val, 0);

    // Back-to-back requests for flows 0,1,2 with rdy held high, including pointer wrap.
    do_reset();
    alloc_flow(0); alloc_flow(1); alloc_flow(2);
    for (int f = 0; f < 3; f++) begin
      upd_val = '0;
      set_upd(0, f, SCHED_FLAG_DATA, SCHED_FLAG_SET);
      step();
    end
    upd_val = '0;
    rdy = 1'b1;
    k = 0;
    for (int c = 0; c < 1500 && k < 6; c++) begin
      if (a_val) begin
        ids[k] = int'(a_id);
        at[k] = c;
        k++;
      end
      step();
    end
    rdy = 1'b0;
    exp_ids = '{0, 1, 2, 0, 1, 2};
    exp_gap = '{0, 2, 2, MAXF - 1, 2, 2};
    chk("rr_req_count", k, 6);
    for (int i = 0; i < k; i++) chk($sformatf("rr_id%0d", i), ids[i], exp_ids[i]);
    for (int i = 1; i < k; i++) chk($sformatf("rr_gap%0d", i), at[i] - at[i-1], exp_gap[i]);

    // Clear-on-grant: same-cycle update on the handshake wins over the clear.
    do_reset();
    alloc_flow(5);
    set_upd(0, 5, SCHED_FLAG_RT, SCHED_FLAG_SET);
    step();
    upd_val = '0;
    wait_val(1'b1, MAXF + 2, got);
    chk("cog_req1_seen", got, 1);
    chk("cog_req1_id", b_id, 5);
    chk("cog_req1_flags", b_flags, 3'b001);
    rdy = 1'b1;
    set_upd(0, 5, SCHED_FLAG_DATA, SCHED_FLAG_SET);
    #1;
    chk("cog_upd_rdy", b_upd_rdy, 3'b001);
    step();
    rdy = 1'b0; upd_val = '0;
    chk("cog_drop_after_hs", b_val, 0);
    wait_val(1'b1, MAXF + 2, got);
    chk("cog_req2_seen", got, 1);
    chk("cog_req2_id", b_id, 5);
    chk("cog_req2_flags", b_flags, 3'b100);
    chk("nocog_req2_val", a_val, 1);
    chk("nocog_req2_flags", a_flags, 3'b101);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    count_reqs(1'b1, 300, nreq);
    chk("cog_cleared_no_req", nreq, 0);

    // Same-cycle collisions on one id and across different ids.
    do_reset();
    alloc_flow(10);
    chk("col_cnt_base", a_cnt, 1);
    del_flow_val = 1'b1; del_flow_flowid = 8'd4; new_flow_val = 1'b1; new_flow_flowid = 8'd4;
    set_upd(0, 4, SCHED_FLAG_RT, SCHED_FLAG_SET);
    step();
    del_flow_val = 1'b0; new_flow_val = 1'b0; upd_val = '0;
    chk("col_unalloc_cnt", a_cnt, 1);
    alloc_flow(4);
    chk("col_alloc4_cnt", a_cnt, 2);
    del_flow_val = 1'b1; del_flow_flowid = 8'd4; new_flow_val = 1'b1; new_flow_flowid = 8'd4;
    set_upd(0, 4, SCHED_FLAG_RT, SCHED_FLAG_SET);
    step();
    del_flow_val = 1'b0; new_flow_val = 1'b0; upd_val = '0;
    chk("col_alloc_del_cnt", a_cnt, 1);
    del_flow_val = 1'b1; del_flow_flowid = 8'd10; new_flow_val = 1'b1; new_flow_flowid = 8'd11;
    step();
    del_flow_val = 1'b0; new_flow_val = 1'b0;
    chk("col_diff_ids_cnt", a_cnt, 1);
    del_flow_val = 1'b1; del_flow_flowid = 8'd20;
    step();
    del_flow_val = 1'b0;
    chk("del_unalloc_cnt", a_cnt, 1);
    set_upd(0, 4, SCHED_FLAG_RT, SCHED_FLAG_SET);
    step();
    upd_val = '0;
    rdy = 1'b1;
    count_reqs(1'b0, 300, nreq);
    rdy = 1'b0;
    chk("col_no_req", nreq, 0);

    // Reset while a request for flow 9 is pending.
    do_reset();
    alloc_flow(9);
    set_upd(0, 9, SCHED_FLAG_DATA, SCHED_FLAG_SET);
    step();
    upd_val = '0;
    wait_val(1'b0, MAXF + 2, got);
    chk("rst9_req_seen", got, 1);
    chk("rst9_req_id", a_id, 9);
    rst = 1'b1;
    step();
    chk("rst9_val_dropped", a_val, 0);
    chk("rst9_cnt", a_cnt, 0);
    rst = 1'b0;
    count_reqs(1'b0, 300, nreq);
    chk("rst9_quiet", nreq, 0);
    alloc_flow(9);
    set_upd(0, 9, SCHED_FLAG_RT, SCHED_FLAG_SET);
    step();
    upd_val = '0;
    wait_val(1'b0, MAXF + 2, got);
    chk("rst9_realloc_seen", got, 1);
    chk("rst9_realloc_flags", a_flags, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
